// File: rtl/atm_ledger.sv
`default_nettype none
// ============================================================================
//  atm_ledger : multi-account, multi-currency balance ledger with
//               bounds, sufficient-funds and overflow checked updates.
//  Revision   : 1.0
// ============================================================================
module atm_ledger #(
    parameter int                         NUM_ACC  = 10,
    parameter int                         NUM_CUR  = 5,
    parameter int                         BAL_W    = 16,
    parameter logic [NUM_CUR*BAL_W-1:0]   INIT_BAL = {16'd10, 16'd100, 16'd10, 16'd5, 16'd500}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [$clog2(NUM_ACC)-1:0]   req_src,
    input  logic [$clog2(NUM_ACC)-1:0]   req_dst,
    input  logic [$clog2(NUM_CUR)-1:0]   req_cur,
    input  logic [BAL_W-1:0]             req_amount,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [3:0]                   rsp_status,
    output logic [BAL_W-1:0]             rsp_balance
);

    localparam int AW = $clog2(NUM_ACC);
    localparam int CW = $clog2(NUM_CUR);

    localparam logic [AW:0]    C_NUM_ACC = (AW+1)'(NUM_ACC);
    localparam logic [CW:0]    C_NUM_CUR = (CW+1)'(NUM_CUR);
    localparam logic [BAL_W:0] C_BAL_MAX = {1'b0, {BAL_W{1'b1}}};

    localparam logic [1:0] C_OP_QUERY    = 2'b00;
    localparam logic [1:0] C_OP_WITHDRAW = 2'b01;
    localparam logic [1:0] C_OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] C_OP_XFER     = 2'b11;

    localparam logic [3:0] C_AMT_VALID     = 4'b0101;
    localparam logic [3:0] C_AMT_INVALID   = 4'b0110;
    localparam logic [3:0] C_ACC_NOT_FOUND = 4'b0010;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LOAD = 2'd1;
    localparam logic [1:0] C_ST_EXEC = 2'd2;
    localparam logic [1:0] C_ST_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [AW-1:0]     src_q, src_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [CW-1:0]     cur_q, cur_d;
    logic [BAL_W-1:0]  amount_q, amount_d;
    logic [BAL_W-1:0]  bal_src_q, bal_src_d;
    logic [BAL_W-1:0]  bal_dst_q, bal_dst_d;
    logic [3:0]        rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]  rsp_balance_q, rsp_balance_d;
    logic [BAL_W-1:0]  mem_q [NUM_ACC][NUM_CUR];
    logic [BAL_W-1:0]  mem_d [NUM_ACC][NUM_CUR];

    logic              src_in, dst_in, cur_in;
    logic [BAL_W:0]    sum_src, sum_dst;
    logic              funds_ok, src_room, dst_room;
    logic [3:0]        exec_status;
    logic [BAL_W-1:0]  exec_balance;
    logic              wr_src, wr_dst;
    logic [BAL_W-1:0]  wr_src_val, wr_dst_val;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (req_valid) state_d = C_ST_LOAD;
            C_ST_LOAD: state_d = C_ST_EXEC;
            C_ST_EXEC: state_d = C_ST_RESP;
            C_ST_RESP: if (rsp_ready) state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == C_ST_IDLE);
        rsp_valid   = (state_q == C_ST_RESP);
        rsp_status  = rsp_status_q;
        rsp_balance = rsp_balance_q;
    end

    // ------------------------------------------------------------------
    // Request evaluation (consumed only in EXEC)
    // ------------------------------------------------------------------
    assign src_in   = ({1'b0, src_q} < C_NUM_ACC);
    assign dst_in   = ({1'b0, dst_q} < C_NUM_ACC);
    assign cur_in   = ({1'b0, cur_q} < C_NUM_CUR);
    assign sum_src  = {1'b0, bal_src_q} + {1'b0, amount_q};
    assign sum_dst  = {1'b0, bal_dst_q} + {1'b0, amount_q};
    assign funds_ok = (amount_q <= bal_src_q);
    assign src_room = (sum_src <= C_BAL_MAX);
    assign dst_room = (sum_dst <= C_BAL_MAX);

    always_comb begin
        exec_status  = C_AMT_INVALID;
        exec_balance = bal_src_q;
        wr_src       = 1'b0;
        wr_dst       = 1'b0;
        wr_src_val   = bal_src_q;
        wr_dst_val   = sum_dst[BAL_W-1:0];
        if (!src_in || ((op_q == C_OP_XFER) && !dst_in)) begin
            exec_status  = C_ACC_NOT_FOUND;
            exec_balance = '0;
        end else if (cur_in) begin
            case (op_q)
                C_OP_QUERY: begin
                    exec_status = C_AMT_VALID;
                end
                C_OP_WITHDRAW: begin
                    if (funds_ok) begin
                        wr_src       = 1'b1;
                        wr_src_val   = bal_src_q - amount_q;
                        exec_status  = C_AMT_VALID;
                        exec_balance = bal_src_q - amount_q;
                    end
                end
                C_OP_DEPOSIT: begin
                    if (src_room) begin
                        wr_src       = 1'b1;
                        wr_src_val   = sum_src[BAL_W-1:0];
                        exec_status  = C_AMT_VALID;
                        exec_balance = sum_src[BAL_W-1:0];
                    end
                end
                default: begin
                    // Transfer commits both legs or neither.
                    if ((src_q != dst_q) && funds_ok && dst_room) begin
                        wr_src       = 1'b1;
                        wr_dst       = 1'b1;
                        wr_src_val   = bal_src_q - amount_q;
                        exec_status  = C_AMT_VALID;
                        exec_balance = bal_src_q - amount_q;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        op_d          = op_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cur_d         = cur_q;
        amount_d      = amount_q;
        bal_src_d     = bal_src_q;
        bal_dst_d     = bal_dst_q;
        rsp_status_d  = rsp_status_q;
        rsp_balance_d = rsp_balance_q;
        if ((state_q == C_ST_IDLE) && req_valid) begin
            op_d     = req_op;
            src_d    = req_src;
            dst_d    = req_dst;
            cur_d    = req_cur;
            amount_d = req_amount;
        end
        if (state_q == C_ST_LOAD) begin
            bal_src_d = (src_in && cur_in) ? mem_q[src_q][cur_q] : '0;
            bal_dst_d = (dst_in && cur_in) ? mem_q[dst_q][cur_q] : '0;
        end
        if (state_q == C_ST_EXEC) begin
            rsp_status_d  = exec_status;
            rsp_balance_d = exec_balance;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == C_ST_EXEC) begin
            if (wr_src) mem_d[src_q][cur_q] = wr_src_val;
            if (wr_dst) mem_d[dst_q][cur_q] = wr_dst_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            cur_q         <= '0;
            amount_q      <= '0;
            bal_src_q     <= '0;
            bal_dst_q     <= '0;
            rsp_status_q  <= '0;
            rsp_balance_q <= '0;
            for (int a = 0; a < NUM_ACC; a++) begin
                for (int c = 0; c < NUM_CUR; c++) begin
                    mem_q[a][c] <= INIT_BAL[c*BAL_W +: BAL_W];
                end
            end
        end else begin
            op_q          <= op_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            cur_q         <= cur_d;
            amount_q      <= amount_d;
            bal_src_q     <= bal_src_d;
            bal_dst_q     <= bal_dst_d;
            rsp_status_q  <= rsp_status_d;
            rsp_balance_q <= rsp_balance_d;
            mem_q         <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atm_ledger.sv
`default_nettype none
// ============================================================================
//  tb_atm_ledger : directed + randomized bench for atm_ledger against a
//                  plain-arithmetic balance-sheet model.
//  Revision      : 1.0
// ============================================================================
module tb_atm_ledger;

    localparam int NUM_ACC = 10;
    localparam int NUM_CUR = 5;
    localparam int BAL_MAX = 65535;
    localparam int ST_VALID = 5;
    localparam int ST_INVALID = 6;
    localparam int ST_NOT_FOUND = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [2:0]  req_cur;
    logic [15:0] req_amount;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_status;
    logic [15:0] rsp_balance;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned model_bal [NUM_ACC][NUM_CUR];

    atm_ledger dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_cur     (req_cur),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        int unsigned init_cur [NUM_CUR];
        init_cur = '{500, 5, 10, 100, 10};
        for (int a = 0; a < NUM_ACC; a++)
            for (int c = 0; c < NUM_CUR; c++)
                model_bal[a][c] = init_cur[c];
    endtask

    // Issue one request, check latency/handshake, hold the response 'hold' cycles.
    task automatic do_req(input int op, input int src, input int dst, input int cur,
                          input int amt, input int hold);
        int exp_st;
        int exp_bal;
        bit chk_bal;
        int unsigned bs;
        int unsigned bd;
        exp_bal = 0;
        chk_bal = 1'b1;
        if (src >= NUM_ACC || (op == 3 && dst >= NUM_ACC)) begin
            exp_st = ST_NOT_FOUND;
        end else if (cur >= NUM_CUR) begin
            exp_st  = ST_INVALID;
            chk_bal = 1'b0;
        end else begin
            bs = model_bal[src][cur];
            exp_st = ST_INVALID;
            case (op)
                0: exp_st = ST_VALID;
                1: if (amt <= bs) begin
                       model_bal[src][cur] = bs - amt;
                       exp_st = ST_VALID;
                   end
                2: if (bs + amt <= BAL_MAX) begin
                       model_bal[src][cur] = bs + amt;
                       exp_st = ST_VALID;
                   end
                default: begin
                    bd = model_bal[dst][cur];
                    if (src != dst && amt <= bs && bd + amt <= BAL_MAX) begin
                        model_bal[src][cur] = bs - amt;
                        model_bal[dst][cur] = bd + amt;
                        exp_st = ST_VALID;
                    end
                end
            endcase
            exp_bal = model_bal[src][cur];
        end

        @(negedge clk);
        req_op     = op[1:0];
        req_src    = src[3:0];
        req_dst    = dst[3:0];
        req_cur    = cur[2:0];
        req_amount = amt[15:0];
        req_valid  = 1'b1;
        @(posedge clk); #1;
        check_val("busy_after_accept", req_ready, 0);
        check_val("no_early_rsp_e0", rsp_valid, 0);
        req_op     = 2'($urandom);
        req_src    = 4'($urandom);
        req_dst    = 4'($urandom);
        req_cur    = 3'($urandom);
        req_amount = 16'($urandom);
        @(posedge clk); #1;
        check_val("no_early_rsp_e1", rsp_valid, 0);
        @(posedge clk); #1;
        check_val("rsp_valid_e2", rsp_valid, 1);
        check_val("status", rsp_status, exp_st);
        if (chk_bal) check_val("balance", rsp_balance, exp_bal);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", rsp_valid, 1);
            check_val("hold_busy", req_ready, 0);
            check_val("hold_status", rsp_status, exp_st);
            if (chk_bal) check_val("hold_balance", rsp_balance, exp_bal);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("rsp_taken", rsp_valid, 0);
        check_val("ready_again", req_ready, 1);
    endtask

    initial begin
        int op;
        int src;
        int dst;
        int cur;
        int amt;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_src    = '0;
        req_dst    = '0;
        req_cur    = '0;
        req_amount = '0;
        rsp_ready  = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_status", rsp_status, 0);
        check_val("rst_rsp_balance", rsp_balance, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        do_req(0, 3, 0, 0, 0, 0);
        do_req(1, 2, 0, 1, 5, 0);
        do_req(1, 2, 0, 1, 1, 0);
        do_req(3, 0, 7, 3, 40, 0);
        do_req(0, 7, 0, 3, 0, 0);
        do_req(3, 0, 7, 3, 61, 0);
        do_req(0, 7, 0, 3, 0, 0);
        do_req(2, 1, 0, 0, 65035, 0);
        do_req(2, 1, 0, 0, 1, 0);
        do_req(3, 4, 1, 0, 1, 0);
        do_req(0, 1, 0, 0, 0, 0);
        do_req(0, 12, 0, 0, 0, 0);
        do_req(1, 12, 0, 0, 1, 0);
        do_req(1, 3, 0, 6, 1, 0);
        do_req(3, 5, 5, 2, 1, 0);
        do_req(3, 5, 13, 2, 1, 0);
        do_req(0, 5, 0, 2, 0, 0);
        do_req(2, 6, 0, 4, 0, 0);
        do_req(0, 3, 0, 0, 0, 5);

        // Reset while a withdraw sits in EXEC
        @(negedge clk);
        req_op = 2'b01; req_src = 4'd6; req_dst = 4'd0; req_cur = 3'd4;
        req_amount = 16'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_rsp_valid", rsp_valid, 0);
        check_val("abort_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        do_req(0, 6, 0, 4, 0, 0);
        do_req(0, 2, 0, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op  = int'($urandom_range(0, 3));
            src = int'($urandom_range(0, 11));
            dst = int'($urandom_range(0, 11));
            cur = int'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       amt = 0;
                1:       amt = int'($urandom_range(0, 20));
                2:       amt = int'($urandom_range(0, 600));
                default: amt = int'($urandom_range(0, 65535));
            endcase
            do_req(op, src, dst, cur, amt, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
